mult_unit_seq: RTL and testbench
================================

Name: mult_unit_seq

Overview:
- Iterative radix-2 shift-add multiplier with architectural HI/LO registers.
- Sits in the execute stage beside the ALU and consumes the controller's start_mult and mult_sign strobes.
- Multiplies the two execute-stage operands and holds the 2*WIDTH-bit product for later HI/LO reads.
- Exposes busy/done so the hazard logic can stall dependent HI/LO reads.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_mult  input  1  single-cycle request to begin a multiply.
- mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult.
- srca_e  input  WIDTH  multiplicand (rs value).
- srcb_e  input  WIDTH  multiplier (rt value).
- mult_busy  output  1  high while an operation is in progress.
- mult_done  output  1  one-cycle pulse when HI/LO have just been updated.
- prod_hi  output  WIDTH  HI register, upper half of last product.
- prod_lo  output  WIDTH  LO register, lower half of last product.

Behaviour:
- Reset (synchronous, on clk edge with reset=1):
  - state=IDLE; mult_busy=0; mult_done=0; prod_hi=0; prod_lo=0; counter=0; internal accumulator cleared.
  - Reset overrides everything, including an operation in progress. The partial result is discarded and HI/LO go to 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start_mult=1, latch the operands.
    - If mult_sign=1, latch |srca_e| and |srcb_e| (two's-complement magnitude, WIDTH-bit unsigned) and set neg_flag = srca_e[MSB] XOR srcb_e[MSB].
    - If mult_sign=0, latch raw operands and set neg_flag=0.
  - Clear the accumulator, set counter=0, go to RUN, assert mult_busy.
  - Without start_mult: stay in IDLE, mult_done=0.
- RUN: one iteration per clk.
  - If the multiplier LSB=1, add the multiplicand into the upper half of the 2*WIDTH+1-bit accumulator.
  - Shift the accumulator right 1 and shift the multiplier right 1; counter++.
  - After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
- FIX: one cycle.
  - Result = neg_flag ? two's-complement negation of the 2*WIDTH-bit accumulator : accumulator.
  - Write {prod_hi, prod_lo} = result; go to IDLE.
  - mult_done=1 and mult_busy=0 for the cycle following this edge.
- Latency:
  - Start accepted at edge E0; RUN spans edges E1..E32 (WIDTH=32); FIX at E33.
  - HI/LO become valid and mult_done pulses in the cycle after E33: 34 cycles from request.
  - mult_busy is high from after E0 through the cycle after E32.
- Boundary conditions:
  - start_mult while mult_busy=1 is ignored; the operation in progress is unaffected.
  - start_mult in the mult_done cycle is accepted (state is IDLE). HI/LO keep the just-written value until the new FIX.
  - HI/LO hold their value at all times except the FIX edge and reset.
  - Signed -2^(WIDTH-1) magnitude is 2^(WIDTH-1) and is exact as unsigned, so there is no overflow. The product always fits in 2*WIDTH bits.
  - Zero operand: still takes the full 34 cycles; result 0, no negative zero.
  - mult_sign and operands are ignored outside the start edge.

Test Plan:
- Unsigned 7 x 6 (srca=32'h7, srcb=32'h6, mult_sign=0) -> mult_done 34 cycles after the start edge; HI=32'h0, LO=32'h2A; busy high for exactly 33 cycles.
- Signed -3 x 5 (32'hFFFFFFFD, 32'h5, mult_sign=1) -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. Same operands unsigned -> HI=32'h4, LO=32'hFFFFFFF1.
- Unsigned 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Signed 32'h80000000 x 32'h80000000 -> HI=32'h40000000, LO=32'h0.
- Start 2 x 3, then pulse start_mult with 9 x 9 at cycle 10 while busy -> second request ignored; result HI=0, LO=6; exactly one mult_done pulse.
- Back-to-back: start 4 x 5, then issue start 10 x 10 in the mult_done cycle.
  - LO=20 during the gap.
  - LO=100 with a second mult_done 34 cycles after the second start.
- Complete 7 x 6 (LO=42), then start 100 x 100 and assert reset at cycle 15 for one cycle.
  - busy=0, done=0, HI=LO=0 after the reset edge.
  - No mult_done pulse afterwards until a new start.

Source files
------------

// File: rtl/mult_unit_seq.sv
// Iterative radix-2 shift-add multiplier with architectural HI/LO registers.
// Signed operands are reduced to magnitudes on entry and the sign is
// reapplied in a single fix-up cycle, so the iterative core is unsigned only.
module mult_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    output logic             mult_busy,
    output logic             mult_done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PW:0]        acc_reg, acc_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic               neg_reg, neg_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which is still exact as an unsigned WIDTH-bit number.
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [PW-1:0]      result;

    assign abs_a = (mult_sign && srca_e[WIDTH-1]) ? (~srca_e + WIDTH'(1)) : srca_e;
    assign abs_b = (mult_sign && srcb_e[WIDTH-1]) ? (~srcb_e + WIDTH'(1)) : srcb_e;

    // Upper half of the accumulator plus the multiplicand when the current
    // multiplier bit is set; the extra accumulator bit catches the carry.
    assign sum = acc_reg[PW:WIDTH] + {1'b0, (mplier_reg[0] ? mcand_reg : '0)};

    // Sign fix-up of the finished magnitude product.
    assign result = neg_reg ? (~acc_reg[PW-1:0] + PW'(1)) : acc_reg[PW-1:0];

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            neg_reg    <= neg_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
        end
    end

    // Next-state and datapath control: accept in IDLE, iterate in RUN,
    // sign-correct and publish HI/LO in FIX.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        neg_next    = neg_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_mult) begin
                    mcand_next  = abs_a;
                    mplier_next = abs_b;
                    neg_next    = mult_sign & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                acc_next    = {1'b0, sum, acc_reg[WIDTH-1:1]};
                mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                hi_next    = result[PW-1:WIDTH];
                lo_next    = result[WIDTH-1:0];
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mult_busy = (state_reg != IDLE);
    assign mult_done = done_reg;
    assign prod_hi   = hi_reg;
    assign prod_lo   = lo_reg;

endmodule

// File: tb/tb_mult_unit_seq.sv
// Self-checking bench for mult_unit_seq: a latency/product model is compared
// against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_mult_unit_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start_mult;
    logic             mult_sign;
    logic [WIDTH-1:0] srca_e;
    logic [WIDTH-1:0] srcb_e;
    logic             mult_busy;
    logic             mult_done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    int tests_run;
    int tests_failed;
    int cyc;
    int req_cyc;
    int busy_cnt;
    int done_cnt;

    // Model state: cycles remaining until HI/LO are written, pending product.
    int          m_remaining;
    logic [63:0] m_pending;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_done;
    logic        m_valid;

    mult_unit_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .srca_e     (srca_e),
        .srcb_e     (srcb_e),
        .mult_busy  (mult_busy),
        .mult_done  (mult_done),
        .prod_hi    (prod_hi),
        .prod_lo    (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Behavioural model: a request is accepted only when nothing is pending;
    // HI/LO appear 33 edges after the accepting edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_remaining = 0;
            m_hi = '0;
            m_lo = '0;
            m_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_remaining > 0) begin
                m_remaining = m_remaining - 1;
                if (m_remaining == 0) begin
                    m_hi = m_pending[63:32];
                    m_lo = m_pending[31:0];
                    m_done = 1'b1;
                end
            end else if (start_mult) begin
                m_pending = ref_product(srca_e, srcb_e, mult_sign);
                m_remaining = 33;
            end
        end
    end

    // Per-cycle compare against the model, plus busy/done bookkeeping.
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(mult_busy), 64'(m_remaining != 0));
            check("done", 64'(mult_done), 64'(m_done));
            check("hi", 64'(prod_hi), 64'(m_hi));
            check("lo", 64'(prod_lo), 64'(m_lo));
        end
        if (mult_busy) busy_cnt++;
        if (mult_done) done_cnt++;
    end

    // Drive a one-cycle start; caller is positioned at a negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        start_mult = 1'b1;
        srca_e = a;
        srcb_e = b;
        mult_sign = s;
        req_cyc = cyc;
        @(negedge clk);
        start_mult = 1'b0;
        srca_e = 32'hDEAD_BEEF;
        srcb_e = 32'h1234_5678;
        mult_sign = ~s;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        issue(a, b, s);
    endtask

    // Wait for mult_done with a cycle budget; returns at the done-cycle negedge.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (mult_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (mult_done !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: mult_done not seen within 100 cycles", name);
        end
    endtask

    task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] hi, input logic [31:0] lo);
        start_op(a, b, s);
        wait_done(name);
        check({name, "_lat"}, 64'(cyc - req_cyc), 64'd34);
        check({name, "_hi"}, 64'(prod_hi), 64'(hi));
        check({name, "_lo"}, 64'(prod_lo), 64'(lo));
    endtask

    initial begin
        int d0;
        tests_run = 0;
        tests_failed = 0;
        cyc = 0;
        busy_cnt = 0;
        done_cnt = 0;
        m_valid = 1'b0;
        m_remaining = 0;
        m_pending = '0;
        m_hi = '0;
        m_lo = '0;
        m_done = 1'b0;
        reset = 1'b1;
        start_mult = 1'b0;
        mult_sign = 1'b0;
        srca_e = '0;
        srcb_e = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(mult_busy), 64'd0);
        check("rst_done", 64'(mult_done), 64'd0);
        check("rst_hi", 64'(prod_hi), 64'd0);
        check("rst_lo", 64'(prod_lo), 64'd0);

        // Unsigned 7 x 6, with busy duration
        @(negedge clk);
        busy_cnt = 0;
        issue(32'h7, 32'h6, 1'b0);
        wait_done("u7x6");
        check("u7x6_lat", 64'(cyc - req_cyc), 64'd34);
        check("u7x6_hi", 64'(prod_hi), 64'h0);
        check("u7x6_lo", 64'(prod_lo), 64'h2A);
        @(negedge clk);
        check("u7x6_busy_cycles", 64'(busy_cnt), 64'd33);

        run_case("s_m3x5", 32'hFFFF_FFFD, 32'h5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_case("u_m3x5", 32'hFFFF_FFFD, 32'h5, 1'b0, 32'h4, 32'hFFFF_FFF1);
        run_case("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1);
        run_case("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);
        run_case("s_zero", 32'h0, 32'hFFFF_FFF9, 1'b1, 32'h0, 32'h0);

        // Start while busy is ignored
        @(negedge clk);
        d0 = done_cnt;
        issue(32'd2, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        issue(32'd9, 32'd9, 1'b0);
        wait_done("busy_ign");
        check("busy_ign_lat", 64'(cyc - req_cyc + 9), 64'd34);
        check("busy_ign_hi", 64'(prod_hi), 64'h0);
        check("busy_ign_lo", 64'(prod_lo), 64'd6);
        repeat (45) @(negedge clk);
        check("busy_ign_pulses", 64'(done_cnt - d0), 64'd1);

        // Back-to-back: new start in the done cycle
        start_op(32'd4, 32'd5, 1'b0);
        wait_done("b2b_first");
        check("b2b_first_lo", 64'(prod_lo), 64'd20);
        issue(32'd10, 32'd10, 1'b0);
        repeat (10) @(negedge clk);
        check("b2b_gap_lo", 64'(prod_lo), 64'd20);
        check("b2b_gap_busy", 64'(mult_busy), 64'd1);
        wait_done("b2b_second");
        check("b2b_second_lat", 64'(cyc - req_cyc), 64'd34);
        check("b2b_second_lo", 64'(prod_lo), 64'd100);

        // Reset aborts an operation in flight
        run_case("pre_rst", 32'h7, 32'h6, 1'b0, 32'h0, 32'h2A);
        start_op(32'd100, 32'd100, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(mult_busy), 64'd0);
        check("abort_done", 64'(mult_done), 64'd0);
        check("abort_hi", 64'(prod_hi), 64'd0);
        check("abort_lo", 64'(prod_lo), 64'd0);
        d0 = done_cnt;
        repeat (50) @(negedge clk);
        @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
